sram_burst_bridge: RTL and testbench
====================================

Name: sram_burst_bridge

Overview:
- Parametrised successor to the single-word software-to-SRAM writer.
- Moves words between a software handshake port (to_hw_sig/to_sw_sig) and an asynchronous SRAM.
- Supports write and read-back modes, a programmable base address, auto-increment with wrap at DEPTH, and a programmable access pulse width.
- Sits between the soft-core PIO registers and the board SRAM pins.

Parameters:
- DATA_W, 16, SRAM data width in bits.
- ADDR_W, 20, SRAM address width in bits.
- DEPTH, 1<<ADDR_W, number of addressable words; address wraps at DEPTH-1 to 0; must be at most 1<<ADDR_W.
- ACCESS_CYCLES, 2, clock cycles WE or OE is held low per access; legal range 1 to 15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- to_hw_sig  in  2  software command: 0=GO, 1=ARM/NEXT, 2=END, 3=reserved (treated as hold)
- to_sw_sig  out  2  status: 0=IDLE, 1=READY, 2=DONE, 3=RESET
- mode  in  1  0=write, 1=read; sampled on IDLE->PREPARE only
- base_addr  in  ADDR_W  start address; sampled on IDLE->PREPARE only
- to_hw_port  in  DATA_W  write data from software
- from_hw_port  out  DATA_W  read data captured from SRAM
- word_count  out  ADDR_W+1  number of accesses completed since the last ARM from IDLE
- wrapped  out  1  sticky flag: address wrapped during the current burst
- Data  inout  DATA_W  SRAM data bus
- ADDR  out  ADDR_W  SRAM address
- OE, WE, CE, LB, UB  out  1 each  SRAM controls, active low

Behaviour:
- All outputs are registered except Data.
- Reset values: state=RST, to_sw_sig=3, OE=1, WE=1, ADDR=0, from_hw_port=0, word_count=0, wrapped=0, CE=0. A reset asserted mid-access forces WE=1 and OE=1 at the next edge and releases Data.
- RST: leave unconditionally after one cycle, to IDLE.
- IDLE (to_sw_sig=0): on to_hw_sig==1, latch mode and base_addr, set ADDR=base_addr, clear word_count and wrapped, go to PREPARE.
- PREPARE (to_sw_sig=1): WE=OE=1.
  - to_hw_sig==0 -> ACCESS.
  - to_hw_sig==2 -> IDLE.
  - Otherwise stay.
- ACCESS (to_sw_sig=2): lasts exactly ACCESS_CYCLES cycles, counted by an internal counter.
  - Write mode: WE=0, OE=1, Data driven with to_hw_port.
  - Read mode: OE=0, WE=1, Data high-Z. from_hw_port is captured on the last ACCESS cycle.
- HOLD (to_sw_sig=2): one cycle with WE=OE=1.
  - Write mode: Data is still driven, giving one cycle of data hold. Data is released on exit.
  - Read mode: Data is high-Z.
  - word_count increments by 1 on entry to HOLD.
- DONE (to_sw_sig=2): wait for software.
  - to_hw_sig==1 -> PREPARE, with the address advanced.
  - to_hw_sig==2 -> IDLE, with ADDR unchanged.
- Address advance: ADDR = (ADDR==DEPTH-1) ? 0 : ADDR+1. On wrap, set wrapped=1.
- word_count saturates at 1<<ADDR_W and does not roll over.
- to_hw_port is sampled every ACCESS cycle. Software must hold it stable from the GO command until DONE is seen.
- mode and base_addr changes outside IDLE are ignored.
- to_hw_sig==3 in any state is treated as no change (stay).
- CE=0 whenever not in reset.

Optional Feature:
- Macro: SRAM_BYTE_LANE_EN.
- When defined:
  - Adds input byte_en[1:0], active high, bit0=low byte and bit1=high byte.
  - byte_en is sampled on PREPARE->ACCESS.
  - LB = ~byte_en[0] and UB = ~byte_en[1] during ACCESS and HOLD; both are 1 otherwise.
  - byte_en==0 skips the SRAM access but still advances word_count.
- When undefined: no byte_en port, and LB=UB=0 constantly.

Test Plan:
- Reset held 3 cycles mid-ACCESS in write mode -> WE=1, OE=1, to_sw_sig=3 the cycle after the edge, Data high-Z, then to_sw_sig=0 one cycle after release.
- Write burst: base_addr=0x00010, ACCESS_CYCLES=2, words 0xA5A5, 0x1234, 0xBEEF -> ADDR 0x10, 0x11, 0x12; WE low exactly 2 cycles per word; Data matches each word; word_count=3; wrapped=0.
- Read back the same 3 words with mode=1 -> OE low 2 cycles each, WE stays 1, Data never driven, from_hw_port shows 0xA5A5, 0x1234, 0xBEEF at successive DONE states.
- Wrap: DEPTH=16, base_addr=15, two writes -> second access at ADDR=0, wrapped=1, word_count=2.
- END command from PREPARE and from DONE -> return to IDLE, no WE pulse, ADDR unchanged. A mode change while in DONE is ignored on the next word.
- SRAM_BYTE_LANE_EN defined, byte_en=2'b01 -> LB=0 and UB=1 during ACCESS. byte_en=0 -> no WE pulse, word_count still increments.

Source files
------------

// File: rtl/sram_burst_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_bridge_if
// Brief    : Software handshake + SRAM control bundle for sram_burst_bridge.
//            The optional byte_en lane exists only with SRAM_BYTE_LANE_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_burst_bridge_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    logic [1:0]        to_hw_sig;
    logic [1:0]        to_sw_sig;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [DATA_W-1:0] to_hw_port;
    logic [DATA_W-1:0] from_hw_port;
    logic [ADDR_W:0]   word_count;
    logic              wrapped;
    logic [ADDR_W-1:0] ADDR;
    logic              OE;
    logic              WE;
    logic              CE;
    logic              LB;
    logic              UB;
`ifdef SRAM_BYTE_LANE_EN
    logic [1:0]        byte_en;
`endif

    modport slave (
`ifdef SRAM_BYTE_LANE_EN
        input  byte_en,
`endif
        input  to_hw_sig, mode, base_addr, to_hw_port,
        output to_sw_sig, from_hw_port, word_count, wrapped,
        output ADDR, OE, WE, CE, LB, UB
    );

    modport master (
`ifdef SRAM_BYTE_LANE_EN
        output byte_en,
`endif
        output to_hw_sig, mode, base_addr, to_hw_port,
        input  to_sw_sig, from_hw_port, word_count, wrapped,
        input  ADDR, OE, WE, CE, LB, UB
    );
endinterface
`default_nettype wire

// File: rtl/sram_burst_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_bridge
// Brief    : Burst word mover between a software handshake port and an async
//            SRAM; write/read-back, auto-increment with wrap at DEPTH.
//            Optional per-byte lane enables with SRAM_BYTE_LANE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_burst_bridge #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 20,
    parameter int DEPTH         = 1 << ADDR_W,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    sram_burst_bridge_if.slave bus,
    inout  wire  [DATA_W-1:0] Data
);
    typedef enum logic [2:0] {
        S_RST     = 3'd0,
        S_IDLE    = 3'd1,
        S_PREPARE = 3'd2,
        S_ACCESS  = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [1:0]        c_CMD_GO    = 2'd0;
    localparam logic [1:0]        c_CMD_ARM   = 2'd1;
    localparam logic [1:0]        c_CMD_END   = 2'd2;
    localparam logic [1:0]        c_SW_IDLE   = 2'd0;
    localparam logic [1:0]        c_SW_READY  = 2'd1;
    localparam logic [1:0]        c_SW_DONE   = 2'd2;
    localparam logic [1:0]        c_SW_RESET  = 2'd3;
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        c_CNT_LAST  = 4'(ACCESS_CYCLES - 1);
    localparam logic [ADDR_W:0]   c_WC_MAX    = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    logic [1:0]        r_sw;
    logic [3:0]        r_cnt;
    logic              r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_oe;
    logic              r_drive;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W:0]   r_wc;
    logic              r_wrapped;
    logic              w_lane_go;
    logic              w_lane_act;

`ifdef SRAM_BYTE_LANE_EN
    logic [1:0]        r_be;
    logic              r_lb;
    logic              r_ub;

    // A zero lane mask runs the access timing without touching the SRAM.
    assign w_lane_go  = |bus.byte_en;
    assign w_lane_act = |r_be;
    assign bus.LB     = r_lb;
    assign bus.UB     = r_ub;
`else
    assign w_lane_go  = 1'b1;
    assign w_lane_act = 1'b1;
    assign bus.LB     = 1'b0;
    assign bus.UB     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RST;
            r_sw      <= c_SW_RESET;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b1;
            r_oe      <= 1'b1;
            r_drive   <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_wc      <= '0;
            r_wrapped <= 1'b0;
`ifdef SRAM_BYTE_LANE_EN
            r_be      <= 2'b00;
            r_lb      <= 1'b1;
            r_ub      <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_RST: begin
                    r_state <= S_IDLE;
                    r_sw    <= c_SW_IDLE;
                end
                S_IDLE: begin
                    if (bus.to_hw_sig == c_CMD_ARM) begin
                        r_mode    <= bus.mode;
                        r_addr    <= bus.base_addr;
                        r_wc      <= '0;
                        r_wrapped <= 1'b0;
                        r_state   <= S_PREPARE;
                        r_sw      <= c_SW_READY;
                    end
                end
                S_PREPARE: begin
                    r_we <= 1'b1;
                    r_oe <= 1'b1;
                    if (bus.to_hw_sig == c_CMD_GO) begin
                        r_state <= S_ACCESS;
                        r_sw    <= c_SW_DONE;
                        r_cnt   <= '0;
                        r_wdata <= bus.to_hw_port;
                        r_we    <= ~(w_lane_go & ~r_mode);
                        r_oe    <= ~(w_lane_go & r_mode);
                        r_drive <= w_lane_go & ~r_mode;
`ifdef SRAM_BYTE_LANE_EN
                        r_be    <= bus.byte_en;
                        r_lb    <= ~bus.byte_en[0];
                        r_ub    <= ~bus.byte_en[1];
`endif
                    end else if (bus.to_hw_sig == c_CMD_END) begin
                        r_state <= S_IDLE;
                        r_sw    <= c_SW_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_wdata <= bus.to_hw_port;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_HOLD;
                        r_we    <= 1'b1;
                        r_oe    <= 1'b1;
                        if (r_mode && w_lane_act) begin
                            r_rdata <= Data;
                        end
                        if (r_wc != c_WC_MAX) begin
                            r_wc <= r_wc + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    // Write data stays on the bus through this cycle for hold time.
                    r_state <= S_DONE;
                    r_drive <= 1'b0;
`ifdef SRAM_BYTE_LANE_EN
                    r_lb    <= 1'b1;
                    r_ub    <= 1'b1;
`endif
                end
                S_DONE: begin
                    if (bus.to_hw_sig == c_CMD_ARM) begin
                        r_state <= S_PREPARE;
                        r_sw    <= c_SW_READY;
                        if (r_addr == c_ADDR_LAST) begin
                            r_addr    <= '0;
                            r_wrapped <= 1'b1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end else if (bus.to_hw_sig == c_CMD_END) begin
                        r_state <= S_IDLE;
                        r_sw    <= c_SW_IDLE;
                    end
                end
                default: begin
                    r_state <= S_RST;
                    r_sw    <= c_SW_RESET;
                end
            endcase
        end
    end

    assign Data             = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign bus.to_sw_sig    = r_sw;
    assign bus.from_hw_port = r_rdata;
    assign bus.word_count   = r_wc;
    assign bus.wrapped      = r_wrapped;
    assign bus.ADDR         = r_addr;
    assign bus.WE           = r_we;
    assign bus.OE           = r_oe;
    assign bus.CE           = 1'b0;
endmodule
`default_nettype wire

// File: tb/tb_sram_burst_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_burst_bridge
// Brief    : Bench for sram_burst_bridge: main instance plus a DEPTH=16
//            instance for wrap, with pulled-up data buses and SRAM models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_burst_bridge;
    localparam int DW      = 16;
    localparam int AWA     = 20;
    localparam int AWB     = 4;
    localparam int ACC_A   = 2;
    localparam int ACC_B   = 3;
    localparam int DEPTH_B = 16;
    localparam logic [1:0] C_GO  = 2'd0;
    localparam logic [1:0] C_ARM = 2'd1;
    localparam logic [1:0] C_END = 2'd2;
    localparam logic [1:0] C_NOP = 2'd3;

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        sel    = 1'b0;
    logic [1:0]  cmd    = C_NOP;
    logic        mode_i = 1'b0;
    logic [19:0] base_i = '0;
    logic [15:0] wdata  = '0;
`ifdef SRAM_BYTE_LANE_EN
    logic [1:0]  be     = 2'b11;
`endif
    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];

    logic        s_we   [8];
    logic        s_oe   [8];
    logic        s_lb   [8];
    logic        s_ub   [8];
    logic [15:0] s_data [8];
    logic [19:0] s_addr [8];

    always #5 clk = ~clk;

    sram_burst_bridge_if #(.DATA_W(DW), .ADDR_W(AWA)) busA ();
    sram_burst_bridge_if #(.DATA_W(DW), .ADDR_W(AWB)) busB ();
    wire [DW-1:0] DataA;
    wire [DW-1:0] DataB;

    assign busA.to_hw_sig  = sel ? C_NOP : cmd;
    assign busB.to_hw_sig  = sel ? cmd : C_NOP;
    assign busA.mode       = mode_i;
    assign busB.mode       = mode_i;
    assign busA.base_addr  = base_i;
    assign busB.base_addr  = base_i[AWB-1:0];
    assign busA.to_hw_port = wdata;
    assign busB.to_hw_port = wdata;
`ifdef SRAM_BYTE_LANE_EN
    assign busA.byte_en    = be;
    assign busB.byte_en    = be;
`endif

    sram_burst_bridge #(.DATA_W(DW), .ADDR_W(AWA), .ACCESS_CYCLES(ACC_A)) dutA (
        .clk(clk), .reset(rst), .bus(busA), .Data(DataA));
    sram_burst_bridge #(.DATA_W(DW), .ADDR_W(AWB), .DEPTH(DEPTH_B), .ACCESS_CYCLES(ACC_B)) dutB (
        .clk(clk), .reset(rst), .bus(busB), .Data(DataB));

    // Released buses float to all ones.
    for (genvar g = 0; g < DW; g++) begin : g_pull
        pullup (DataA[g]);
        pullup (DataB[g]);
    end

    // Asynchronous SRAM models: write on WE rising edge, read while OE low.
    logic [15:0] memA [256];
    logic [15:0] memB [16];
    assign DataA = !busA.OE ? memA[busA.ADDR[7:0]] : {DW{1'bz}};
    assign DataB = !busB.OE ? memB[busB.ADDR] : {DW{1'bz}};

    always @(posedge busA.WE) begin
        if (!rst) begin
            if (!busA.LB) memA[busA.ADDR[7:0]][7:0]  <= DataA[7:0];
            if (!busA.UB) memA[busA.ADDR[7:0]][15:8] <= DataA[15:8];
        end
    end
    always @(posedge busB.WE) begin
        if (!rst) begin
            if (!busB.LB) memB[busB.ADDR][7:0]  <= DataB[7:0];
            if (!busB.UB) memB[busB.ADDR][15:8] <= DataB[15:8];
        end
    end

    wire [1:0]  o_sw      = sel ? busB.to_sw_sig : busA.to_sw_sig;
    wire        o_we      = sel ? busB.WE : busA.WE;
    wire        o_oe      = sel ? busB.OE : busA.OE;
    wire        o_ce      = sel ? busB.CE : busA.CE;
    wire        o_lb      = sel ? busB.LB : busA.LB;
    wire        o_ub      = sel ? busB.UB : busA.UB;
    wire        o_wrapped = sel ? busB.wrapped : busA.wrapped;
    wire [19:0] o_addr    = sel ? {16'd0, busB.ADDR} : busA.ADDR;
    wire [20:0] o_wc      = sel ? {16'd0, busB.word_count} : busA.word_count;
    wire [15:0] o_rd      = sel ? busB.from_hw_port : busA.from_hw_port;
    wire [15:0] o_data    = sel ? DataB : DataA;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        @(negedge clk);
        cmd = c;
        step();
        cmd = C_NOP;
    endtask

    // Issues GO and records ACCESS..DONE, one sample per cycle.
    task automatic run_word(input logic [15:0] wd);
        int acc;
        acc = sel ? ACC_B : ACC_A;
        @(negedge clk);
        wdata = wd;
        cmd   = C_GO;
        for (int k = 0; k <= acc + 1; k++) begin
            step();
            if (k == 0) cmd = C_NOP;
            s_we[k]   = o_we;
            s_oe[k]   = o_oe;
            s_lb[k]   = o_lb;
            s_ub[k]   = o_ub;
            s_data[k] = o_data;
            s_addr[k] = o_addr;
        end
    endtask

    task automatic test_reset();
        logic lane_rst;
`ifdef SRAM_BYTE_LANE_EN
        lane_rst = 1'b1;
`else
        lane_rst = 1'b0;
`endif
        sel = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        n_tests++; if (o_sw !== 2'd3) begin n_fail++; $display("FAIL rst_sw: got %0d want 3", o_sw); end
        n_tests++; if ({o_we, o_oe, o_ce} !== 3'b110) begin n_fail++; $display("FAIL rst_we_oe_ce: got %b want 110", {o_we, o_oe, o_ce}); end
        n_tests++; if (o_addr !== 20'h0 || o_rd !== 16'h0) begin n_fail++; $display("FAIL rst_addr_rd: got %h/%h want 0/0", o_addr, o_rd); end
        n_tests++; if (o_wc !== 21'd0 || o_wrapped !== 1'b0) begin n_fail++; $display("FAIL rst_wc_wrap: got %0d/%b want 0/0", o_wc, o_wrapped); end
        n_tests++; if (o_lb !== lane_rst || o_ub !== lane_rst) begin n_fail++; $display("FAIL rst_lanes: got %b%b want %b%b", o_lb, o_ub, lane_rst, lane_rst); end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_tests++; if (o_sw !== 2'd0) begin n_fail++; $display("FAIL rst_to_idle: got %0d want 0", o_sw); end

        mode_i = 1'b0;
        base_i = 20'h00010;
        send(C_ARM);
        @(negedge clk);
        wdata = 16'h5555;
        cmd   = C_GO;
        step();
        cmd = C_NOP;
        n_tests++; if (o_we !== 1'b0 || o_data !== 16'h5555) begin n_fail++; $display("FAIL rst_pre_access: got we=%b data=%h want 0/5555", o_we, o_data); end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_tests++; if ({o_we, o_oe} !== 2'b11 || o_sw !== 2'd3) begin n_fail++; $display("FAIL rst_mid_access: got we/oe=%b sw=%0d want 11/3", {o_we, o_oe}, o_sw); end
        n_tests++; if (o_data !== 16'hFFFF || o_addr !== 20'h0) begin n_fail++; $display("FAIL rst_mid_release: got data=%h addr=%h want FFFF/0", o_data, o_addr); end
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
        step();
        n_tests++; if (o_sw !== 2'd0) begin n_fail++; $display("FAIL rst_release_idle: got %0d want 0", o_sw); end
    endtask

    task automatic test_write_burst();
        logic [15:0] words [3];
        exp_t e;
        int we_lo, oe_lo, bad;
        words[0] = 16'hA5A5;
        words[1] = 16'h1234;
        words[2] = 16'hBEEF;
        sel    = 1'b0;
        mode_i = 1'b0;
        base_i = 20'h00010;
        send(C_ARM);
        n_tests++; if (o_sw !== 2'd1 || o_addr !== 20'h10 || o_wc !== 21'd0) begin n_fail++; $display("FAIL wr_arm: got sw=%0d addr=%h wc=%0d want 1/10/0", o_sw, o_addr, o_wc); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) send(C_ARM);
            sb_q.push_back('{addr: 20'h10 + 20'(i), data: words[i]});
            run_word(words[i]);
            e = sb_q.pop_front();
            we_lo = 0; oe_lo = 0; bad = 0;
            for (int k = 0; k <= ACC_A + 1; k++) begin
                if (!s_we[k]) we_lo++;
                if (!s_oe[k]) oe_lo++;
                if (k <= ACC_A && s_data[k] !== e.data) bad++;
                if (s_addr[k] !== e.addr) bad++;
            end
            if (s_data[ACC_A + 1] !== 16'hFFFF) bad++;
            n_tests++; if (we_lo != ACC_A || oe_lo != 0) begin n_fail++; $display("FAIL wr_pulse[%0d]: got we_lo=%0d oe_lo=%0d want %0d/0", i, we_lo, oe_lo, ACC_A); end
            n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wr_bus[%0d]: got %0d bad samples want 0 (addr %h data %h)", i, bad, e.addr, e.data); end
            n_tests++; if (o_wc !== 21'(i + 1) || o_sw !== 2'd2) begin n_fail++; $display("FAIL wr_done[%0d]: got wc=%0d sw=%0d want %0d/2", i, o_wc, o_sw, i + 1); end
        end
        n_tests++; if (o_wrapped !== 1'b0) begin n_fail++; $display("FAIL wr_wrapped: got %b want 0", o_wrapped); end
        send(C_END);
        n_tests++; if (o_sw !== 2'd0 || o_addr !== 20'h12) begin n_fail++; $display("FAIL wr_end: got sw=%0d addr=%h want 0/12", o_sw, o_addr); end
    endtask

    task automatic test_read_back();
        logic [15:0] words [3];
        exp_t e;
        int we_lo, oe_lo, bad;
        words[0] = 16'hA5A5;
        words[1] = 16'h1234;
        words[2] = 16'hBEEF;
        sel    = 1'b0;
        mode_i = 1'b1;
        base_i = 20'h00010;
        send(C_ARM);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) send(C_ARM);
            sb_q.push_back('{addr: 20'h10 + 20'(i), data: words[i]});
            run_word(16'h0000);
            e = sb_q.pop_front();
            we_lo = 0; oe_lo = 0; bad = 0;
            for (int k = 0; k <= ACC_A + 1; k++) begin
                if (!s_we[k]) we_lo++;
                if (!s_oe[k]) oe_lo++;
                if (s_oe[k] && s_data[k] !== 16'hFFFF) bad++;
                if (s_addr[k] !== e.addr) bad++;
            end
            n_tests++; if (oe_lo != ACC_A || we_lo != 0) begin n_fail++; $display("FAIL rd_pulse[%0d]: got oe_lo=%0d we_lo=%0d want %0d/0", i, oe_lo, we_lo, ACC_A); end
            n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rd_bus[%0d]: got %0d bad samples want 0", i, bad); end
            n_tests++; if (o_rd !== e.data) begin n_fail++; $display("FAIL rd_data[%0d]: got %h want %h", i, o_rd, e.data); end
        end
        n_tests++; if (o_wc !== 21'd3) begin n_fail++; $display("FAIL rd_wc: got %0d want 3", o_wc); end
        send(C_END);
        mode_i = 1'b0;
    endtask

    task automatic test_wrap();
        int we_lo;
        sel    = 1'b1;
        mode_i = 1'b0;
        base_i = 20'd15;
        send(C_ARM);
        n_tests++; if (o_addr !== 20'd15 || o_wrapped !== 1'b0) begin n_fail++; $display("FAIL wrap_arm: got addr=%0d wrapped=%b want 15/0", o_addr, o_wrapped); end
        run_word(16'h1111);
        we_lo = 0;
        for (int k = 0; k <= ACC_B + 1; k++) if (!s_we[k]) we_lo++;
        n_tests++; if (we_lo != ACC_B || s_addr[0] !== 20'd15) begin n_fail++; $display("FAIL wrap_first: got we_lo=%0d addr=%0d want %0d/15", we_lo, s_addr[0], ACC_B); end
        send(C_ARM);
        n_tests++; if (o_addr !== 20'd0 || o_wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_advance: got addr=%0d wrapped=%b want 0/1", o_addr, o_wrapped); end
        run_word(16'h2222);
        n_tests++; if (s_addr[0] !== 20'd0 || o_wc !== 21'd2 || o_wrapped !== 1'b1) begin n_fail++; $display("FAIL wrap_second: got addr=%0d wc=%0d wrapped=%b want 0/2/1", s_addr[0], o_wc, o_wrapped); end
        n_tests++; if (memB[0] !== 16'h2222 || memB[15] !== 16'h1111) begin n_fail++; $display("FAIL wrap_mem: got %h/%h want 2222/1111", memB[0], memB[15]); end
        send(C_END);
        send(C_ARM);
        n_tests++; if (o_wrapped !== 1'b0 || o_wc !== 21'd0) begin n_fail++; $display("FAIL wrap_rearm: got wrapped=%b wc=%0d want 0/0", o_wrapped, o_wc); end
        send(C_END);
        sel = 1'b0;
    endtask

    task automatic test_end_cmds();
        int we_lo, oe_lo;
        sel    = 1'b0;
        mode_i = 1'b0;
        base_i = 20'h00020;
        send(C_ARM);
        send(C_END);
        n_tests++; if (o_sw !== 2'd0 || o_addr !== 20'h20 || o_we !== 1'b1) begin n_fail++; $display("FAIL end_prepare: got sw=%0d addr=%h we=%b want 0/20/1", o_sw, o_addr, o_we); end
        send(C_ARM);
        run_word(16'h7777);
        mode_i = 1'b1;
        base_i = 20'h00055;
        send(C_ARM);
        n_tests++; if (o_addr !== 20'h21) begin n_fail++; $display("FAIL end_advance: got %h want 21", o_addr); end
        run_word(16'h8888);
        we_lo = 0; oe_lo = 0;
        for (int k = 0; k <= ACC_A + 1; k++) begin
            if (!s_we[k]) we_lo++;
            if (!s_oe[k]) oe_lo++;
        end
        n_tests++; if (we_lo != ACC_A || oe_lo != 0 || s_data[0] !== 16'h8888) begin n_fail++; $display("FAIL end_mode_ignored: got we_lo=%0d oe_lo=%0d data=%h want %0d/0/8888", we_lo, oe_lo, s_data[0], ACC_A); end
        send(C_END);
        n_tests++; if (o_sw !== 2'd0 || o_addr !== 20'h21) begin n_fail++; $display("FAIL end_done: got sw=%0d addr=%h want 0/21", o_sw, o_addr); end
        mode_i = 1'b0;
    endtask

`ifdef SRAM_BYTE_LANE_EN
    task automatic test_byte_lane();
        int bad, we_lo;
        sel    = 1'b0;
        mode_i = 1'b0;
        base_i = 20'h00030;
        be     = 2'b01;
        send(C_ARM);
        run_word(16'hCAFE);
        bad = 0;
        for (int k = 0; k <= ACC_A; k++) if (s_lb[k] !== 1'b0 || s_ub[k] !== 1'b1) bad++;
        if (s_lb[ACC_A + 1] !== 1'b1 || s_ub[ACC_A + 1] !== 1'b1) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL lane_lb_ub: got %0d bad samples want 0", bad); end
        n_tests++; if (memA[8'h30][7:0] !== 8'hFE) begin n_fail++; $display("FAIL lane_low_byte: got %h want fe", memA[8'h30][7:0]); end
        be = 2'b00;
        send(C_ARM);
        run_word(16'hDEAD);
        we_lo = 0;
        for (int k = 0; k <= ACC_A + 1; k++) if (!s_we[k]) we_lo++;
        n_tests++; if (we_lo != 0 || o_wc !== 21'd2) begin n_fail++; $display("FAIL lane_skip: got we_lo=%0d wc=%0d want 0/2", we_lo, o_wc); end
        send(C_END);
        be = 2'b11;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_burst();
        test_read_back();
        test_wrap();
        test_end_cmds();
`ifdef SRAM_BYTE_LANE_EN
        test_byte_lane();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
